adder_switch_pipe: RTL

//  Parametrised, pipelined reduction-network adder switch (next-gen adder switch for the ART).

---
 rtl/adder_switch_pipe_if.sv | 28 ++
 rtl/adder_switch_pipe.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adder_switch_pipe_if.sv
// adder_switch_pipe_if: operand bus, command and output bundle of one adder-tree switch
// master: upstream/test driver (drives i_*, reads o_*); slave: the switch itself.
interface adder_switch_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SEL_IN     = 1
);
  logic                         i_valid;
  logic [DATA_WIDTH*NUM_IN-1:0] i_data_bus;
  logic [SEL_IN-1:0]            i_sel;
  logic [2:0]                   i_cmd;
  logic                         i_last;
  logic                         i_stall;
  logic                         o_ready;
  logic                         o_valid;
  logic [2*DATA_WIDTH-1:0]      o_adder;
  logic [2*DATA_WIDTH-1:0]      o_vn;
  logic [1:0]                   o_vn_valid;
  logic                         o_accum_busy;
  modport master (
    output i_valid, i_data_bus, i_sel, i_cmd, i_last, i_stall,
    input  o_ready, o_valid, o_adder, o_vn, o_vn_valid, o_accum_busy
  );
  modport slave (
    input  i_valid, i_data_bus, i_sel, i_cmd, i_last, i_stall,
    output o_ready, o_valid, o_adder, o_vn, o_vn_valid, o_accum_busy
  );
endinterface

// File: rtl/adder_switch_pipe.sv
// adder_switch_pipe: pipelined reduction-network adder switch (add / forward / VN emit)
// Ports: clk, rst (async, active-high), io (adder_switch_pipe_if.slave):
//   i_valid/i_data_bus/i_sel/i_cmd/i_last in, i_stall back-pressure, o_ready = ~i_stall,
//   o_valid/o_adder result, o_vn/o_vn_valid virtual-neuron outputs, o_accum_busy.
// Optional macro ADDER_SWITCH_ACCUM_EN enables the cmd 110 accumulator.
module adder_switch_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SEL_IN     = 1,
  parameter int ADD_LAT    = 2
) (
  input logic             clk,
  input logic             rst,
  adder_switch_pipe_if.slave io
);
  localparam int DW = DATA_WIDTH;
  typedef struct packed {
    logic          valid;
    logic [2:0]    cmd;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] s;
`ifdef ADDER_SWITCH_ACCUM_EN
    logic          last;
`endif
  } stage_t;
  stage_t in_s, head;
  logic [DW-1:0] l_sel, r_sel;
  // Out-of-range selects fall through to pair 0.
  always_comb begin
    l_sel = io.i_data_bus[DW +: DW];
    r_sel = io.i_data_bus[0 +: DW];
    for (int k = 1; k < NUM_IN / 2; k++)
      if (io.i_sel == SEL_IN'(k)) begin
        l_sel = io.i_data_bus[(2*k+1)*DW +: DW];
        r_sel = io.i_data_bus[2*k*DW +: DW];
      end
  end
  always_comb begin
    in_s = '0;
    in_s.valid = io.i_valid;
    in_s.cmd = io.i_cmd;
    in_s.l = l_sel;
    in_s.r = r_sel;
    in_s.s = l_sel + r_sel;
`ifdef ADDER_SWITCH_ACCUM_EN
    in_s.last = io.i_last;
`endif
  end
  // ADD_LAT-1 stage registers, the output registers provide the final cycle.
  generate
    if (ADD_LAT == 1) begin : g_direct
      assign head = in_s;
    end else begin : g_pipe
      stage_t pipe_q [ADD_LAT-1];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          for (int i = 0; i < ADD_LAT - 1; i++) pipe_q[i] <= '0;
        end else if (!io.i_stall) begin
          pipe_q[0] <= in_s;
          for (int i = 1; i < ADD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      assign head = pipe_q[ADD_LAT-2];
    end
  endgenerate
  logic          v;
  logic [2:0]    c;
  logic          acc_hit;
  logic [DW-1:0] acc_sum;
  logic [DW-1:0] au_q, au_d, al_q, al_d, vu_q, vu_d, vl_q, vl_d;
  logic          valid_q, valid_d;
  logic [1:0]    vnv_q, vnv_d;
  assign v = head.valid;
  assign c = head.cmd;
`ifdef ADDER_SWITCH_ACCUM_EN
  logic          acc_beat, busy_q, busy_d;
  logic [DW-1:0] acc_q, acc_d;
  // ACC is zero when idle, so ACC+S covers both the first beat and a lone last beat.
  always_comb begin
    acc_beat = v && c == 3'b110;
    acc_hit = acc_beat && head.last;
    acc_sum = acc_q + head.s;
    acc_d = acc_beat ? (head.last ? '0 : acc_sum) : acc_q;
    busy_d = acc_beat ? !head.last : busy_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      busy_q <= 1'b0;
    end else if (!io.i_stall) begin
      acc_q <= acc_d;
      busy_q <= busy_d;
    end
  assign io.o_accum_busy = busy_q;
`else
  assign acc_hit = 1'b0;
  assign acc_sum = '0;
  assign io.o_accum_busy = 1'b0;
`endif
  always_comb begin
    au_d = !v ? au_q : (c == 3'd1 || c == 3'd4) ? head.l : c == 3'd2 ? head.s : acc_hit ? acc_sum : au_q;
    al_d = !v ? al_q : (c == 3'd1 || c == 3'd3) ? head.r : c == 3'd2 ? head.s : acc_hit ? acc_sum : al_q;
    vu_d = (v && (c == 3'd3 || c == 3'd5)) ? head.l : vu_q;
    vl_d = (v && (c == 3'd4 || c == 3'd5)) ? head.r : vl_q;
    vnv_d = {v && (c == 3'd3 || c == 3'd5), v && (c == 3'd4 || c == 3'd5)};
    valid_d = v && ((c >= 3'd1 && c <= 3'd4) || acc_hit);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      au_q <= '0;
      al_q <= '0;
      vu_q <= '0;
      vl_q <= '0;
      vnv_q <= '0;
      valid_q <= 1'b0;
    end else if (!io.i_stall) begin
      au_q <= au_d;
      al_q <= al_d;
      vu_q <= vu_d;
      vl_q <= vl_d;
      vnv_q <= vnv_d;
      valid_q <= valid_d;
    end
  assign io.o_ready = ~io.i_stall;
  assign io.o_valid = valid_q;
  assign io.o_adder = {au_q, al_q};
  assign io.o_vn = {vu_q, vl_q};
  assign io.o_vn_valid = vnv_q;
endmodule
